// File: rtl/cpu_pkg.sv
// Shared datapath constants: the common word width and the default reset word,
// so every datapath register takes both from one place.
package cpu_pkg;

    localparam int DATA_WIDTH = 32;

    // Wide enough for the largest legal register width (64); slice to WIDTH.
    localparam logic [63:0] REG_RESET_DEFAULT = 64'h0;

    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/register.sv
// register: WIDTH-bit edge-triggered storage with synchronous active-high
// reset and active-high load enable. Priority on each rising Clk edge is
// Rst, then En, then hold. Q comes straight from the flops.
// Optional simulation checker compiled in with `define REGISTER_CHECK_EN.
module register
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = DATA_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = REG_RESET_DEFAULT[WIDTH-1:0]
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    output logic [WIDTH-1:0] Q
);

    // Storage: reset wins over load; D is not looked at unless En is set.
    always_ff @(posedge Clk) begin
        if (Rst)
            Q <= RESET_VALUE;
        else if (En)
            Q <= D;
    end

`ifdef REGISTER_CHECK_EN
    // Checker state: armed after the first reset edge; shadow holds what Q
    // should show after the most recent edge.
    logic             armed;
    logic [WIDTH-1:0] shadow;

    // Control/data sanity and shadow compare, all quiet until the first reset.
    always_ff @(posedge Clk) begin
        if (armed === 1'b1) begin
            if ($isunknown(Rst) || $isunknown(En))
                $error("register: Rst/En unknown at clock edge");
            if (En === 1'b1 && Rst !== 1'b1 && $isunknown(D))
                $error("register: loading D with X/Z bits");
            if (Q !== shadow)
                $error("register: Q %h differs from shadow %h", Q, shadow);
        end
        if (Rst === 1'b1)
            armed <= 1'b1;
        if (Rst === 1'b1)
            shadow <= RESET_VALUE;
        else if (En === 1'b1)
            shadow <= D;
    end
`endif

endmodule

// File: tb/tb_register.sv
// Bench for register: a directed vector table from the test plan, two
// between-edge sequences, then random traffic against a behavioural model.
// Three instances: default, 32-bit with a DEADBEEF reset word, and 8-bit.
module tb_register;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        En;
    logic [31:0] D;
    logic [31:0] q32;
    logic [31:0] qrv;
    logic [7:0]  q8;

    int n_checks = 0;
    int n_fail   = 0;

    always #100 Clk = ~Clk;

    register u_dut (
        .Clk(Clk), .Rst(Rst), .D(D), .En(En), .Q(q32)
    );

    register #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF)) u_dut_rv (
        .Clk(Clk), .Rst(Rst), .D(D), .En(En), .Q(qrv)
    );

    register #(.WIDTH(8), .RESET_VALUE(8'hEF)) u_dut8 (
        .Clk(Clk), .Rst(Rst), .D(D[7:0]), .En(En), .Q(q8)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] d;
        logic [31:0] e32;
        logic [31:0] erv;
        logic [7:0]  e8;
    } vec_t;

    vec_t vecs[9];

    // Reference model state (what each register should hold).
    longint unsigned m32, mrv, m8;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+50: drive, wait for the next edge, return at posedge+50.
    task automatic cycle(input logic rst, input logic en, input logic [31:0] d);
        Rst = rst; En = en; D = d;
        @(posedge Clk);
        #50;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e32,
                           input logic [31:0] erv, input logic [7:0] e8);
        chk({tag, ".q32"}, {32'h0, q32}, {32'h0, e32});
        chk({tag, ".qrv"}, {32'h0, qrv}, {32'h0, erv});
        chk({tag, ".q8"},  {56'h0, q8},  {56'h0, e8});
    endtask

    initial begin
        Rst = 1'b0; En = 1'b0; D = '0;
        vecs[0] = '{1'b1, 1'b0, 32'd0,        32'd0,        32'hDEADBEEF, 8'hEF};
        vecs[1] = '{1'b0, 1'b0, 32'd5123,     32'd0,        32'hDEADBEEF, 8'hEF};
        vecs[2] = '{1'b0, 1'b1, 32'd5123,     32'd5123,     32'd5123,     8'h03};
        vecs[3] = '{1'b0, 1'b1, 32'd321,      32'd321,      32'd321,      8'h41};
        vecs[4] = '{1'b0, 1'b0, 32'd3122,     32'd321,      32'd321,      8'h41};
        vecs[5] = '{1'b0, 1'b0, 32'd3122,     32'd321,      32'd321,      8'h41};
        vecs[6] = '{1'b1, 1'b1, 32'd3122,     32'd0,        32'hDEADBEEF, 8'hEF};
        vecs[7] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF};
        vecs[8] = '{1'b0, 1'b1, 32'h0,        32'h0,        32'h0,        8'h00};

        @(posedge Clk);
        #50;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].rst, vecs[i].en, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].e32, vecs[i].erv, vecs[i].e8);
        end

        // En high mid-cycle but low at the edge: no load.
        Rst = 1'b0; En = 1'b1; D = 32'hA5A5A5A5;
        #100;
        En = 1'b0;
        @(posedge Clk);
        #50;
        chk_all("en_glitch", 32'h0, 32'h0, 8'h00);

        // Load something, then pulse Rst between edges: no reset.
        cycle(1'b0, 1'b1, 32'h12345678);
        chk_all("load", 32'h12345678, 32'h12345678, 8'h78);
        Rst = 1'b1; En = 1'b0;
        #100;
        Rst = 1'b0;
        @(posedge Clk);
        #50;
        chk_all("rst_glitch", 32'h12345678, 32'h12345678, 8'h78);

        // Random traffic, opened with a reset so the model starts known.
        for (int i = 0; i < 300; i++) begin
            logic        r, e;
            logic [31:0] d;
            r = (i == 0) || ($urandom_range(0, 9) == 0);
            e = $urandom_range(0, 1) == 1;
            d = $urandom;
            if (r) begin
                m32 = 0;
                mrv = 64'hDEADBEEF;
                m8  = 64'hEF;
            end else if (e) begin
                m32 = d;
                mrv = d;
                m8  = d % 256;
            end
            cycle(r, e, d);
            chk_all($sformatf("rnd%0d", i), m32[31:0], mrv[31:0], m8[7:0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
